// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit.
// Op codes and the op-code type used by the datapath.
package logic_unit_pkg;

  typedef logic [1:0] logic_op_t;

  localparam logic_op_t OP_AND = 2'b00;
  localparam logic_op_t OP_OR  = 2'b01;
  localparam logic_op_t OP_XOR = 2'b10;
  localparam logic_op_t OP_NOR = 2'b11;

  // Bits needed to count up to and including n ones.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/logic_unit_popcount.sv
// Combinational ones counter built as a balanced binary adder tree.
// Leaves are padded to a power of two; each level halves the node count.
module popcount
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CW    = count_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int N  = 1 << LV;

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int M = N >> l;
    logic [CW-1:0] s [M];
    for (genvar i = 0; i < M; i++) begin : g_node
      if (l == 0) begin : g_leaf
        if (i < WIDTH) begin : g_bit
          assign s[i] = CW'(data[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end else begin : g_sum
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign count = g_lvl[LV].s[0];

endmodule

// File: rtl/logic_unit.sv
// 64-bit AND/OR/XOR/NOR unit with combinational result and zero flag,
// plus a registered copy carrying zero flag and ones count.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic_op_t        op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_q,
  output logic             zero_q,
  output logic [CW-1:0]    ones_q
);

  logic [CW-1:0] ones;

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

  assign zero = ~|y;

  popcount #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_popcount (
    .data  (y),
    .count (ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y_q       <= '0;
      zero_q    <= 1'b0;
      ones_q    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q    <= y;
        zero_q <= zero;
        ones_q <= ones;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
// Directed-vector bench for logic_unit.
module tb_logic_unit;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic        in_valid;
  logic [63:0] y;
  logic        zero;
  logic        out_valid;
  logic [63:0] y_q;
  logic        zero_q;
  logic [6:0]  ones_q;

  int vectors;
  int miscompares;

  logic_unit dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .y         (y),
    .zero      (zero),
    .out_valid (out_valid),
    .y_q       (y_q),
    .zero_q    (zero_q),
    .ones_q    (ones_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [63:0] va,
                       input logic [63:0] vb,
                       input logic [1:0]  vop,
                       input logic        vv);
    @(negedge clk);
    a = va;
    b = vb;
    op = vop;
    in_valid = vv;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    op = 2'b00;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y_q", y_q, 64'd0);
    check("rst_zero_q", 64'(zero_q), 64'd0);
    check("rst_ones_q", 64'(ones_q), 64'd0);

    @(negedge clk);
    rst = 1'b0;

    apply(64'hFFFF0000F0F01234, 64'h0F0FFFFF00005678, 2'b00, 1'b1);
    check("and_y", y, 64'h0F0F000000001230);
    check("and_zero", 64'(zero), 64'd0);
    tick();
    check("and_ones_q", 64'(ones_q), 64'd12);
    check("and_y_q", y_q, 64'h0F0F000000001230);
    check("and_out_valid", 64'(out_valid), 64'd1);

    apply(64'hFFFF0000F0F01234, 64'h0F0FFFFF00005678, 2'b01, 1'b1);
    check("or_y", y, 64'hFFFFFFFFF0F0567C);
    check("or_zero", 64'(zero), 64'd0);
    tick();
    check("or_ones_q", 64'(ones_q), 64'd49);
    check("or_out_valid", 64'(out_valid), 64'd1);
    check("or_zero_q", 64'(zero_q), 64'd0);

    apply(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 2'b10, 1'b1);
    check("xor_y", y, 64'hFFFFFFFFFFFFFFFF);
    tick();
    check("xor_ones_q", 64'(ones_q), 64'd64);

    apply(64'h0, 64'hFFFFFFFFFFFFFFFF, 2'b11, 1'b1);
    check("nor_y", y, 64'h0);
    check("nor_zero", 64'(zero), 64'd1);
    tick();
    check("nor_zero_q", 64'(zero_q), 64'd1);
    check("nor_ones_q", 64'(ones_q), 64'd0);
    check("nor_y_q", y_q, 64'h0);

    // XOR of equal operands, then NOR of zeros gives all ones
    apply(64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 2'b10, 1'b1);
    check("xor_eq_y", y, 64'h0);
    check("xor_eq_zero", 64'(zero), 64'd1);
    apply(64'h0, 64'h0, 2'b11, 1'b1);
    check("nor00_y", y, 64'hFFFFFFFFFFFFFFFF);
    tick();
    check("nor00_ones_q", 64'(ones_q), 64'd64);
    check("nor00_zero_q", 64'(zero_q), 64'd0);

    // Hold: inputs change with in_valid low
    apply(64'h00000000000000F0, 64'h000000000000000F, 2'b01, 1'b0);
    check("hold_y", y, 64'h00000000000000FF);
    tick();
    check("hold_out_valid", 64'(out_valid), 64'd0);
    check("hold_y_q", y_q, 64'hFFFFFFFFFFFFFFFF);
    check("hold_ones_q", 64'(ones_q), 64'd64);
    check("hold_zero_q", 64'(zero_q), 64'd0);

    // Capture a small value, then reset between edges
    apply(64'h00000000000000F0, 64'h000000000000000F, 2'b01, 1'b1);
    tick();
    check("cap_ones_q", 64'(ones_q), 64'd8);
    check("cap_y_q", y_q, 64'h00000000000000FF);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_y_q", y_q, 64'h0);
    check("mid_rst_ones_q", 64'(ones_q), 64'd0);
    check("mid_rst_zero_q", 64'(zero_q), 64'd0);
    a = 64'hF000000000000000;
    b = 64'h0000000000000000;
    op = 2'b01;
    #1;
    check("rst_y_tracks", y, 64'hF000000000000000);
    tick();
    check("rst_hold_y_q", y_q, 64'h0);
    check("rst_hold_out_valid", 64'(out_valid), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_ones_q", 64'(ones_q), 64'd4);
    check("post_rst_y_q", y_q, 64'hF000000000000000);
    check("post_rst_out_valid", 64'(out_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_unit.md
# logic_unit

64-bit bitwise logic unit for the single-cycle CPU datapath. It computes AND, OR, XOR or NOR of two operands, selected by a 2-bit op code, with a purely combinational result. The ALU result mux and branch/flag logic consume the combinational result. A registered copy carries a zero flag and a population count for the pipelined status/debug path.

## Interface
Parameters:
- `WIDTH`, default 64: operand and result width.
- `CW`, default `$clog2(WIDTH+1)` (7 at 64): width of the ones-count output.

Ports (clock and reset first):
- `clk` input, 1 bit: single clock; all registers on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `a` input, `WIDTH` bits: operand A.
- `b` input, `WIDTH` bits: operand B.
- `op` input, 2 bits: operation select.
- `in_valid` input, 1 bit: qualifies capture into the output registers.
- `y` output, `WIDTH` bits: combinational result.
- `zero` output, 1 bit: combinational; 1 when `y == 0`.
- `out_valid` output, 1 bit: registered `in_valid`.
- `y_q` output, `WIDTH` bits: registered `y`.
- `zero_q` output, 1 bit: registered `zero`.
- `ones_q` output, `CW` bits: registered count of 1 bits in `y`.

## Operation
- Op encoding:
  - 00 AND: `y = a & b`
  - 01 OR: `y = a | b`
  - 10 XOR: `y = a ^ b`
  - 11 NOR: `y = ~(a | b)`
- All operations are bitwise per bit position, with no carries and no sign handling; the full `WIDTH` is produced.
- `y` and `zero` depend only on `a`, `b` and `op`. They are independent of `clk`, `rst` and `in_valid`.
- If any of `op`, `a` or `b` carries X/Z, `y` may be X. Known inputs must never produce X or Z.
- Register stage, on each rising edge of `clk` while `rst` is low:
  - `out_valid <= in_valid`.
  - When `in_valid` = 1: `y_q <= y`, `zero_q <= zero`, `ones_q <= popcount(y)`.
  - When `in_valid` = 0: `y_q`, `zero_q` and `ones_q` hold their previous values.
- `ones_q` range is 0..`WIDTH` (0..64), unsigned. It must not wrap at `WIDTH` (64 needs 7 bits).

## Timing
- `y` and `zero` have zero-cycle latency. They must be settled within the 5 ns combinational budget after any input change.
- Registered outputs have one-cycle latency: the values sampled at edge N appear after edge N, with `out_valid` high in the same cycle.
- Reset values: `out_valid` = 0, `y_q` = 0, `zero_q` = 0, `ones_q` = 0.
  - Reset is applied immediately on `rst` assertion, with no clock required.
  - Reset is released synchronously, on the first rising edge after `rst` falls.
- Reset mid-stream discards the in-flight capture. `y` and `zero` keep tracking inputs during reset.
- Back-to-back `in_valid` is supported every cycle, with no stalls or backpressure.

## Structure
- Shared package `logic_unit_pkg`:
  - `localparam`s `OP_AND`=2'b00, `OP_OR`=2'b01, `OP_XOR`=2'b10, `OP_NOR`=2'b11.
  - typedef `logic_op_t` for the 2-bit op code.
- One natural sub-module, `popcount`, parameterised by `WIDTH`. It is a combinational adder tree returning a `CW`-bit count.
- The top level holds the op mux, the zero-detect reduction NOR and the output register stage.

## Test plan
- AND, a=FFFF0000F0F01234, b=0F0FFFFF00005678, op=00:
  - `y`=0F0F000000001230 after 5 ns; `zero`=0.
  - With `in_valid`=1, next edge gives `ones_q`=12.
- OR, same a and b, op=01:
  - `y`=FFFFFFFFF0F0567C; `zero`=0.
  - Registered: `ones_q`=49, `out_valid`=1.
- XOR, a=AAAAAAAAAAAAAAAA, b=5555555555555555, op=10:
  - `y`=FFFFFFFFFFFFFFFF; `ones_q`=64 with no wrap.
- NOR, a=0, b=FFFFFFFFFFFFFFFF, op=11:
  - `y`=0, `zero`=1.
  - Registered: `zero_q`=1, `ones_q`=0.
- Hold and reset:
  - `in_valid`=0 while inputs change: registered outputs hold, `out_valid`=0.
  - Assert `rst` between edges: all registered outputs go to 0 immediately, while `y` still follows inputs.
